// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and
// bitstream sizing helpers.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bitstream words needed to cover a chain of chain_len bits
    // (the last word may be only partially used).
    function automatic int words_for(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: holds one bitstream word, presents its MSB and
// shifts it out one bit per cycle. Shifting in zeros means the register is
// already all-zero once the last bit has left, so the serial output is
// naturally 0 while starved.
module ccff_word_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic              shift,
    output logic              head,
    output logic              wv,
    output logic              last_bit
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] sreg_reg;
    logic              wv_reg;
    logic [IDX_W-1:0]  idx_reg;

    // Clear wins over load (abandon / finished chain), load wins over shift
    // so a new word can land on the same edge the previous word's last bit leaves.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sreg_reg <= '0;
            wv_reg   <= 1'b0;
            idx_reg  <= '0;
        end else if (load) begin
            sreg_reg <= data;
            wv_reg   <= 1'b1;
            idx_reg  <= '0;
        end else if (shift) begin
            sreg_reg <= {sreg_reg[WORD_W-2:0], 1'b0};
            idx_reg  <= idx_reg + IDX_W'(1);
            if (idx_reg == LAST_IDX) begin
                wv_reg <= 1'b0;
            end
        end
    end

    assign head     = sreg_reg[WORD_W-1];
    assign wv       = wv_reg;
    assign last_bit = wv_reg && (idx_reg == LAST_IDX);

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: streams bitstream words MSB-first into the
// fabric CCFF chain, counts shifted bits, flags ones seen on the chain tail
// and reports completion once the whole chain has been written.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              cfg_done,
    output logic              busy,
    output logic              tail_err
);

    localparam logic [CNT_W:0]   LEN_EXT  = (CNT_W + 1)'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] nbits_reg, nbits_next;
    logic             tail_err_reg, tail_err_next;
    logic             busy_reg, cfg_done_reg;

    logic ser_clear, ser_load, ser_shift;
    logic ser_head, ser_wv, ser_last;
    logic last_chain_bit;
    logic room_left;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk      (prog_clk),
        .rst_n    (prog_reset),
        .clear    (ser_clear),
        .load     (ser_load),
        .data     (bs_data),
        .shift    (ser_shift),
        .head     (ser_head),
        .wv       (ser_wv),
        .last_bit (ser_last)
    );

    // The bit being shifted this cycle completes the chain.
    assign last_chain_bit = ser_wv && (nbits_reg == LAST_BIT);

    // Another word is still needed after the bit (if any) shifted this cycle.
    assign room_left = ({1'b0, nbits_reg} + {{CNT_W{1'b0}}, ser_wv}) < LEN_EXT;

    // FSM state register.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, handshake and serializer control.
    always_comb begin
        state_next    = state_reg;
        nbits_next    = nbits_reg;
        tail_err_next = tail_err_reg;
        ser_clear     = 1'b0;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        bs_ready      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next    = ST_LOAD;
                    nbits_next    = '0;
                    tail_err_next = 1'b0;
                    ser_clear     = 1'b1;
                end
            end
            ST_LOAD: begin
                bs_ready  = (!ser_wv || ser_last) && room_left;
                ser_load  = bs_valid && bs_ready;
                ser_shift = ser_wv;
                if (ser_wv) begin
                    nbits_next = nbits_reg + CNT_W'(1);
                    if (ccff_tail) begin
                        tail_err_next = 1'b1;
                    end
                end
                if (last_chain_bit) begin
                    // Drop any unused low bits of a partial final word.
                    state_next = ST_DONE;
                    ser_clear  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit counter, sticky tail flag and registered status outputs.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            nbits_reg    <= '0;
            tail_err_reg <= 1'b0;
            busy_reg     <= 1'b0;
            cfg_done_reg <= 1'b0;
        end else begin
            nbits_reg    <= nbits_next;
            tail_err_reg <= tail_err_next;
            busy_reg     <= (state_next == ST_LOAD);
            cfg_done_reg <= (state_next == ST_DONE);
        end
    end

    assign ccff_head     = ser_head;
    assign ccff_shift_en = ser_wv;
    assign tail_err      = tail_err_reg;
    assign busy          = busy_reg;
    assign cfg_done      = cfg_done_reg;

endmodule
